// File: rtl/node_net_if.sv
// Node-side endpoint of the mesh valid/enable network.
// Buffers core packets in a TX FIFO and injects them into the router's
// local input port; sinks ejected packets into an RX FIFO drained by the
// core. Ejection is never back-pressured, so RX overflow drops packets and
// counts them in a saturating drop counter.
// Optional build macro: NODE_IF_STATS_EN adds o_tx_cnt / o_rx_cnt traffic
// counters (32-bit, wrapping).

package node_net_pkg;
    localparam int PKT_W = 16;
    typedef logic [PKT_W-1:0] packet_t;
endpackage

module node_net_if
    import node_net_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int DROP_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  packet_t           i_pkt,
    input  logic              i_pkt_val,
    output logic              o_pkt_rdy,
    output packet_t           o_net_data,
    output logic              o_net_data_val,
    input  logic              i_net_en,
    input  packet_t           i_net_data,
    input  logic              i_net_data_val,
    output packet_t           o_pkt,
    output logic              o_pkt_val,
    input  logic              i_pkt_rdy,
    output logic [DROP_W-1:0] o_drop_cnt
`ifdef NODE_IF_STATS_EN
    ,
    output logic [31:0]       o_tx_cnt,
    output logic [31:0]       o_rx_cnt
`endif
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_CW = RX_PW + 1;

    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

    // ------------------------------------------------------------------
    // TX FIFO state
    // ------------------------------------------------------------------
    packet_t            tx_mem_q [TX_DEPTH];
    packet_t            tx_mem_d [TX_DEPTH];
    logic [TX_PW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_PW-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic               tx_full_s;
    logic               tx_empty_s;
    logic               tx_push_s;
    logic               tx_pop_s;

    // ------------------------------------------------------------------
    // RX FIFO state
    // ------------------------------------------------------------------
    packet_t            rx_mem_q [RX_DEPTH];
    packet_t            rx_mem_d [RX_DEPTH];
    logic [RX_PW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_PW-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic               rx_full_s;
    logic               rx_empty_s;
    logic               rx_push_s;
    logic               rx_pop_s;
    logic               rx_drop_s;

    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

`ifdef NODE_IF_STATS_EN
    logic [31:0]        tx_stat_q, tx_stat_d;
    logic [31:0]        rx_stat_q, rx_stat_d;
`endif

    // TX status flags and handshake qualifiers from the registered count
    always_comb begin
        tx_full_s  = (tx_cnt_q == TX_FULL_CNT);
        tx_empty_s = (tx_cnt_q == {TX_CW{1'b0}});
        tx_push_s  = i_pkt_val && !tx_full_s;
        tx_pop_s   = !tx_empty_s && i_net_en;
    end

    // TX next-state: storage write, independent pointer advance, occupancy
    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push_s) begin
            tx_mem_d[tx_wr_ptr_q] = i_pkt;
            tx_wr_ptr_d           = tx_wr_ptr_q + TX_PW'(1);
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // RX status flags; a full FIFO still accepts when the core pops this cycle
    always_comb begin
        rx_full_s  = (rx_cnt_q == RX_FULL_CNT);
        rx_empty_s = (rx_cnt_q == {RX_CW{1'b0}});
        rx_pop_s   = !rx_empty_s && i_pkt_rdy;
        if (i_net_data_val) begin
            rx_push_s = !rx_full_s || rx_pop_s;
            rx_drop_s = rx_full_s && !rx_pop_s;
        end else begin
            rx_push_s = 1'b0;
            rx_drop_s = 1'b0;
        end
    end

    // RX next-state: storage write, independent pointer advance, occupancy
    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_push_s) begin
            rx_mem_d[rx_wr_ptr_q] = i_net_data;
            rx_wr_ptr_d           = rx_wr_ptr_q + RX_PW'(1);
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Drop counter: saturates at all-ones so a long overflow never reads low
    always_comb begin
        if (rx_drop_s && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

`ifdef NODE_IF_STATS_EN
    // Traffic counters: network transfers and accepted RX pushes, wrapping
    always_comb begin
        if (tx_pop_s) begin
            tx_stat_d = tx_stat_q + 32'd1;
        end else begin
            tx_stat_d = tx_stat_q;
        end
        if (rx_push_s) begin
            rx_stat_d = rx_stat_q + 32'd1;
        end else begin
            rx_stat_d = rx_stat_q;
        end
    end

    // Traffic counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_stat_q <= 32'd0;
            rx_stat_q <= 32'd0;
        end else begin
            tx_stat_q <= tx_stat_d;
            rx_stat_q <= rx_stat_d;
        end
    end

    assign o_tx_cnt = tx_stat_q;
    assign o_rx_cnt = rx_stat_q;
`endif

    // TX FIFO registers; storage is cleared so nothing stale survives reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
            end
            tx_wr_ptr_q <= {TX_PW{1'b0}};
            tx_rd_ptr_q <= {TX_PW{1'b0}};
            tx_cnt_q    <= {TX_CW{1'b0}};
        end else begin
            tx_mem_q    <= tx_mem_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    // RX FIFO and drop counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
            end
            rx_wr_ptr_q <= {RX_PW{1'b0}};
            rx_rd_ptr_q <= {RX_PW{1'b0}};
            rx_cnt_q    <= {RX_CW{1'b0}};
            drop_cnt_q  <= {DROP_W{1'b0}};
        end else begin
            rx_mem_q    <= rx_mem_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Output presentation: heads are gated to zero while a FIFO is empty
    always_comb begin
        o_pkt_rdy      = !tx_full_s;
        o_net_data_val = !tx_empty_s;
        o_pkt_val      = !rx_empty_s;
        if (!tx_empty_s) begin
            o_net_data = tx_mem_q[tx_rd_ptr_q];
        end else begin
            o_net_data = '0;
        end
        if (!rx_empty_s) begin
            o_pkt = rx_mem_q[rx_rd_ptr_q];
        end else begin
            o_pkt = '0;
        end
    end

    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_node_net_if.sv
// Directed bench for node_net_if. A queue-based model of both FIFOs and the
// drop count is checked against two DUT instances (DROP_W=16 and DROP_W=4)
// every cycle; hand-computed literals pin the model at key points.
module tb_node_net_if;
    import node_net_pkg::*;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic    clk;
    logic    reset_n;
    packet_t i_pkt;
    logic    i_pkt_val;
    logic    i_net_en;
    packet_t i_net_data;
    logic    i_net_data_val;
    logic    i_pkt_rdy;

    logic        o_pkt_rdy, o_net_data_val, o_pkt_val;
    packet_t     o_net_data, o_pkt;
    logic [15:0] o_drop_cnt;
    logic        s_pkt_rdy, s_net_data_val, s_pkt_val;
    packet_t     s_net_data, s_pkt;
    logic [3:0]  s_drop_cnt;
`ifdef NODE_IF_STATS_EN
    logic [31:0] o_tx_cnt, o_rx_cnt, s_tx_cnt, s_rx_cnt;
`endif

    node_net_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DROP_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_pkt(i_pkt), .i_pkt_val(i_pkt_val),
        .o_pkt_rdy(o_pkt_rdy), .o_net_data(o_net_data), .o_net_data_val(o_net_data_val),
        .i_net_en(i_net_en), .i_net_data(i_net_data), .i_net_data_val(i_net_data_val),
        .o_pkt(o_pkt), .o_pkt_val(o_pkt_val), .i_pkt_rdy(i_pkt_rdy),
        .o_drop_cnt(o_drop_cnt)
`ifdef NODE_IF_STATS_EN
        , .o_tx_cnt(o_tx_cnt), .o_rx_cnt(o_rx_cnt)
`endif
    );

    node_net_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DROP_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .i_pkt(i_pkt), .i_pkt_val(i_pkt_val),
        .o_pkt_rdy(s_pkt_rdy), .o_net_data(s_net_data), .o_net_data_val(s_net_data_val),
        .i_net_en(i_net_en), .i_net_data(i_net_data), .i_net_data_val(i_net_data_val),
        .o_pkt(s_pkt), .o_pkt_val(s_pkt_val), .i_pkt_rdy(i_pkt_rdy),
        .o_drop_cnt(s_drop_cnt)
`ifdef NODE_IF_STATS_EN
        , .o_tx_cnt(s_tx_cnt), .o_rx_cnt(s_rx_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state
    packet_t m_tx[$];
    packet_t m_rx[$];
    int      m_drop = 0;
    int      m_txc  = 0;
    int      m_rxc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFOs as queues, updated from the protocol rules
    initial begin
        bit tx_pop, tx_push, rx_pop, rx_room;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_tx.delete();
                m_rx.delete();
                m_drop = 0;
                m_txc  = 0;
                m_rxc  = 0;
            end else begin
                tx_pop  = (m_tx.size() > 0) && i_net_en;
                tx_push = i_pkt_val && (m_tx.size() < TXD);
                rx_pop  = (m_rx.size() > 0) && i_pkt_rdy;
                rx_room = (m_rx.size() < RXD) || rx_pop;
                if (tx_pop) begin
                    void'(m_tx.pop_front());
                    m_txc++;
                end
                if (tx_push) m_tx.push_back(i_pkt);
                if (rx_pop) void'(m_rx.pop_front());
                if (i_net_data_val) begin
                    if (rx_room) begin
                        m_rx.push_back(i_net_data);
                        m_rxc++;
                    end else begin
                        m_drop++;
                    end
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    initial begin
        packet_t e_nd, e_pk;
        int      e_d16, e_d4;
        forever begin
            @(negedge clk);
            e_nd  = (m_tx.size() > 0) ? m_tx[0] : '0;
            e_pk  = (m_rx.size() > 0) ? m_rx[0] : '0;
            e_d16 = (m_drop > 65535) ? 65535 : m_drop;
            e_d4  = (m_drop > 15) ? 15 : m_drop;
            chk("pkt_rdy",      64'(o_pkt_rdy),      64'(m_tx.size() < TXD));
            chk("net_data_val", 64'(o_net_data_val), 64'(m_tx.size() > 0));
            chk("net_data",     64'(o_net_data),     64'(e_nd));
            chk("pkt_val",      64'(o_pkt_val),      64'(m_rx.size() > 0));
            chk("pkt",          64'(o_pkt),          64'(e_pk));
            chk("drop_cnt",     64'(o_drop_cnt),     64'(e_d16));
            chk("sat_net_data", 64'(s_net_data),     64'(e_nd));
            chk("sat_pkt",      64'(s_pkt),          64'(e_pk));
            chk("sat_drop_cnt", 64'(s_drop_cnt),     64'(e_d4));
`ifdef NODE_IF_STATS_EN
            chk("tx_cnt", 64'(o_tx_cnt), 64'(m_txc));
            chk("rx_cnt", 64'(o_rx_cnt), 64'(m_rxc));
            chk("sat_rx_cnt", 64'(s_rx_cnt), 64'(m_rxc));
`endif
        end
    end

    // Advance one clock; inputs change 2 time units after the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n        = 1'b0;
        i_pkt          = '0;
        i_pkt_val      = 1'b0;
        i_net_en       = 1'b0;
        i_net_data     = '0;
        i_net_data_val = 1'b0;
        i_pkt_rdy      = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b1;
        chk("lit_rst_rdy", 64'(o_pkt_rdy), 64'd1);
        chk("lit_rst_val", 64'(o_net_data_val), 64'd0);

        // A, B through TX with the network enabled
        i_net_en  = 1'b1;
        i_pkt     = 16'hA001;
        i_pkt_val = 1'b1;
        cyc();
        chk("lit_t1_a_val",  64'(o_net_data_val), 64'd1);
        chk("lit_t1_a_data", 64'(o_net_data), 64'hA001);
        i_pkt = 16'hB002;
        cyc();
        chk("lit_t1_b_data", 64'(o_net_data), 64'hB002);
        chk("lit_t1_rdy",    64'(o_pkt_rdy), 64'd1);
        i_pkt_val = 1'b0;
        cyc();
        chk("lit_t1_empty", 64'(o_net_data_val), 64'd0);

        // TX fill with network stalled, fifth packet held off
        i_net_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_pkt     = 16'h2000 + 16'(k);
            i_pkt_val = 1'b1;
            cyc();
            if (k == 3) chk("lit_t2_full_rdy", 64'(o_pkt_rdy), 64'd0);
        end
        chk("lit_t2_head", 64'(o_net_data), 64'h2000);
        i_pkt_val = 1'b0;
        i_net_en  = 1'b1;
        repeat (4) cyc();
        chk("lit_t2_drained", 64'(o_net_data_val), 64'd0);

        // Mixed traffic: simultaneous push/pop and pointer wrap on both FIFOs
        for (int k = 0; k < 16; k++) begin
            i_pkt          = 16'h5000 + 16'(k);
            i_pkt_val      = 1'b1;
            i_net_en       = (k % 3) != 0;
            i_net_data     = 16'h6000 + 16'(k);
            i_net_data_val = (k % 2) == 1;
            i_pkt_rdy      = (k % 4) != 1;
            cyc();
        end
        i_pkt_val      = 1'b0;
        i_net_data_val = 1'b0;
        i_net_en       = 1'b1;
        i_pkt_rdy      = 1'b1;
        repeat (6) cyc();

        // RX overflow: 6 deliveries into a 4-deep FIFO with the core stalled
        i_pkt_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_net_data     = 16'h3000 + 16'(k);
            i_net_data_val = 1'b1;
            cyc();
        end
        i_net_data_val = 1'b0;
        cyc();
        chk("lit_t3_drop", 64'(o_drop_cnt), 64'd2);
        chk("lit_t3_head", 64'(o_pkt), 64'h3000);
        i_pkt_rdy = 1'b1;
        repeat (4) cyc();
        chk("lit_t3_empty", 64'(o_pkt_val), 64'd0);

        // Full RX with delivery coinciding with a core pop: no drop
        i_pkt_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_net_data     = 16'h3100 + 16'(k);
            i_net_data_val = 1'b1;
            cyc();
        end
        i_net_data = 16'h3104;
        i_pkt_rdy  = 1'b1;
        cyc();
        i_net_data_val = 1'b0;
        i_pkt_rdy      = 1'b0;
        cyc();
        chk("lit_t4_drop", 64'(o_drop_cnt), 64'd2);
        chk("lit_t4_head", 64'(o_pkt), 64'h3101);
        i_pkt_rdy = 1'b1;
        repeat (4) cyc();

        // Saturation of the 4-bit counter: 4 buffered + 16 dropped
        i_pkt_rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i_net_data     = 16'h4000 + 16'(k);
            i_net_data_val = 1'b1;
            cyc();
        end
        i_net_data_val = 1'b0;
        cyc();
        chk("lit_t5_sat", 64'(s_drop_cnt), 64'd15);
        chk("lit_t5_wide", 64'(o_drop_cnt), 64'd18);

        // Reset with 3 TX and 2 RX entries pending
        i_pkt_rdy = 1'b1;
        repeat (2) cyc();
        i_pkt_rdy = 1'b0;
        i_net_en  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_pkt     = 16'h7000 + 16'(k);
            i_pkt_val = 1'b1;
            cyc();
        end
        i_pkt_val = 1'b0;
        chk("lit_t6_pending", 64'(o_net_data), 64'h7000);
        #1;
        reset_n = 1'b0;
        #1;
        chk("lit_t6_rst_rdy",  64'(o_pkt_rdy), 64'd1);
        chk("lit_t6_rst_nval", 64'(o_net_data_val), 64'd0);
        chk("lit_t6_rst_nd",   64'(o_net_data), 64'd0);
        chk("lit_t6_rst_pval", 64'(o_pkt_val), 64'd0);
        chk("lit_t6_rst_pkt",  64'(o_pkt), 64'd0);
        chk("lit_t6_rst_drop", 64'(o_drop_cnt), 64'd0);
        chk("lit_t6_rst_sdrop", 64'(s_drop_cnt), 64'd0);
        repeat (2) cyc();
        reset_n   = 1'b1;
        i_net_en  = 1'b1;
        i_pkt_rdy = 1'b1;
        repeat (3) cyc();
        chk("lit_t6_no_stale_n", 64'(o_net_data_val), 64'd0);
        chk("lit_t6_no_stale_p", 64'(o_pkt_val), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/node_net_if.md
Name: node_net_if

Overview:
- Node-side endpoint of the mesh valid/enable network protocol; one instance per node.
- Takes packets from the local core, buffers them, and injects them into the router's local input port.
- Sinks packets ejected by the router's local output port into a receive buffer drained by the core.
- The network never back-pressures ejection (local enable is tied high), so this block must always accept ejected packets. Overflow drops are counted.

Parameters:
- TX_DEPTH, 4, transmit FIFO entries; power of two, >=2.
- RX_DEPTH, 4, receive FIFO entries; power of two, >=2.
- DROP_W, 16, width of the receive drop counter.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_pkt  input  packet_t  packet from core to send
- i_pkt_val  input  1  i_pkt valid
- o_pkt_rdy  output  1  TX FIFO can accept i_pkt this cycle
- o_net_data  output  packet_t  packet to network (node's i_data slot)
- o_net_data_val  output  1  o_net_data valid (node's i_data_val slot)
- i_net_en  input  1  network enable (node's o_en slot)
- i_net_data  input  packet_t  ejected packet (node's o_data slot)
- i_net_data_val  input  1  i_net_data valid (node's o_data_val slot)
- o_pkt  output  packet_t  received packet to core
- o_pkt_val  output  1  o_pkt valid
- i_pkt_rdy  input  1  core accepts o_pkt this cycle
- o_drop_cnt  output  DROP_W  ejected packets lost to RX overflow

Behaviour:
- Clock and reset: single clock. reset_n is asynchronous assert, synchronous deassert by the system.
- Reset values: both FIFOs empty, pointers 0, o_drop_cnt 0, o_net_data_val 0, o_pkt_val 0, o_net_data '0, o_pkt '0, o_pkt_rdy 1.
- TX push: occurs when i_pkt_val && o_pkt_rdy. o_pkt_rdy = !tx_full, combinational from the registered count. There is no same-cycle bypass of a full FIFO.
- TX present: o_net_data_val = !tx_empty. o_net_data = head entry when valid, '0 otherwise.
- TX pop (transfer): occurs when o_net_data_val && i_net_en in the same cycle. If i_net_en is low, head data and valid are held stable until the transfer.
- TX latency: a packet pushed in cycle t into an empty FIFO is presented at cycle t+1.
- TX simultaneous push and pop: count is unchanged, and the pointers advance independently with wrap at TX_DEPTH.
- RX: every cycle with i_net_data_val=1 is a delivery. Handling depends on FIFO state:
  - Not full: the packet is pushed.
  - Full with a pop in the same cycle (o_pkt_val && i_pkt_rdy): the packet is pushed, with no drop.
  - Full with no pop: the packet is discarded and o_drop_cnt increments. o_drop_cnt saturates at all-ones and never wraps.
- RX present: o_pkt_val = !rx_empty. o_pkt = head entry when valid, '0 otherwise. Pop occurs when o_pkt_val && i_pkt_rdy. Latency from delivery to o_pkt_val is 1 cycle.
- Counters: count registers are $clog2(DEPTH)+1 bits wide. full = (count == DEPTH), empty = (count == 0).
- Reset mid-operation: all buffered packets are discarded, no partial state survives, and the drop counter clears.

Optional Feature:
- Macro: NODE_IF_STATS_EN.
- When defined, adds two outputs, o_tx_cnt and o_rx_cnt (32 bits each, reset 0, wrapping).
  - o_tx_cnt increments on each network transfer (o_net_data_val && i_net_en).
  - o_rx_cnt increments on each accepted RX push; dropped packets are not counted.
- When undefined, these ports and registers do not exist, and the block behaves identically otherwise.

Test Plan:
- Reset, then core pushes packets A,B with i_net_en=1 -> o_net_data_val rises the cycle after A's push. A then B appear on consecutive cycles. o_pkt_rdy stays 1.
- i_net_en=0, core pushes 5 packets with TX_DEPTH=4 -> o_pkt_rdy drops to 0 after the 4th push, and the 5th is held by the core. o_net_data stays on the first packet. Raising i_net_en drains all 4 in order in 4 cycles.
- i_pkt_rdy=0, network delivers 6 packets with RX_DEPTH=4 -> first 4 are buffered and o_drop_cnt=2. Draining yields the first 4 packets in order.
- RX FIFO full, delivery in the same cycle as a core pop -> packet is accepted and o_drop_cnt is unchanged.
- o_drop_cnt preloaded near saturation (DROP_W=4, 16 overflow deliveries) -> counter holds at 15.
- Assert reset_n with 3 TX and 2 RX entries pending -> outputs immediately take their reset values. After release, no stale packet appears on o_net_data or o_pkt.
